dmem_responder: RTL and testbench

- Data-memory responder: the target end of the core's load/store port.
- Accepts one request at a time over a valid/ready request channel.
- Inserts a configurable number of wait states, performs a byte/half/word access selected by the RV32I fun3, then returns data or an error over a valid/ready response channel.
- Sits behind the MEM stage and gives the pipeline a real multi-cycle memory target for stall/handshake work.

---
 rtl/rv_mem_pkg.sv | 28 ++
 rtl/dmem_lane_align.sv | 60 ++++++
 rtl/dmem_responder.sv | 175 +++++++++++++++++
 tb/tb_dmem_responder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I fun3 encodings,
// responder FSM states and the byte-enable helper.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] byte_enable(input logic [2:0] fun3,
                                               input logic [1:0] addr_lo);
        case (fun3)
            F3_B, F3_BU: return 4'b0001 << addr_lo;
            F3_H, F3_HU: return addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:        return 4'b1111;
            default:     return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering between a 32-bit storage word and a
// byte/half/word access: store enables and replication, load extraction.
module dmem_lane_align
    import rv_mem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  fun3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    // NOTE: every output gets a default first so no path through the case
    // statements can leave one unassigned and infer a latch.
    always_comb begin
        be_o       = we_i ? byte_enable(fun3_i, addr_lo_i) : 4'b0000;
        wdata_o    = wdata_i;
        rdata_o    = 32'd0;
        misalign_o = 1'b0;
        illegal_o  = 1'b0;
        byte_sh    = rword_i >> {addr_lo_i, 3'b000};
        half_sh    = rword_i >> {addr_lo_i[1], 4'b0000};

        case (fun3_i[1:0])
            2'd0:    wdata_o = {4{wdata_i[7:0]}};
            2'd1:    wdata_o = {2{wdata_i[15:0]}};
            default: wdata_o = wdata_i;
        endcase

        case (fun3_i)
            F3_B:    rdata_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
            F3_BU:   rdata_o = {24'd0, byte_sh[7:0]};
            F3_H:    rdata_o = {{16{half_sh[15]}}, half_sh[15:0]};
            F3_HU:   rdata_o = {16'd0, half_sh[15:0]};
            F3_W:    rdata_o = rword_i;
            default: rdata_o = 32'd0;
        endcase

        case (fun3_i[1:0])
            2'd1:    misalign_o = addr_lo_i[0];
            2'd2:    misalign_o = |addr_lo_i;
            default: misalign_o = 1'b0;
        endcase

        if (we_i) begin
            illegal_o = fun3_i > F3_W;
        end else begin
            illegal_o = (fun3_i == 3'd3) || (fun3_i[2:1] == 2'b11);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, performs the access and holds the response until taken.
module dmem_responder
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_BITS   = $clog2(DEPTH_WORDS) + 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_fun3_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [31:0] HI_MASK = ~((32'd1 << ADDR_BITS) - 32'd1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  fun3_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_fun3;
    logic [ADDR_BITS-3:0] idx;
    logic [31:0] rword;
    logic [3:0]  be;
    logic [31:0] wdata_al;
    logic [31:0] ld_rdata;
    logic        misalign;
    logic        illegal;
    logic        range_err;
    logic        acc_err;
    logic        accept;
    logic        enter_resp;
    logic        mem_we;
    logic [31:0] rsp_rdata_d;
    logic        rsp_err_d;

    // With zero wait states the access runs on the accept edge itself, so
    // the request is taken straight from the ports rather than the latches.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = req_we_i;
            cur_addr  = req_addr_i;
            cur_wdata = req_wdata_i;
            cur_fun3  = req_fun3_i;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_fun3  = fun3_q;
        end
    end

    assign idx       = cur_addr[ADDR_BITS-1:2];
    assign rword     = mem[idx];
    assign range_err = |(cur_addr & HI_MASK);
    assign acc_err   = misalign | illegal | range_err;

    dmem_lane_align u_align (
        .we_i       (cur_we),
        .fun3_i     (cur_fun3),
        .addr_lo_i  (cur_addr[1:0]),
        .wdata_i    (cur_wdata),
        .rword_i    (rword),
        .be_o       (be),
        .wdata_o    (wdata_al),
        .rdata_o    (ld_rdata),
        .misalign_o (misalign),
        .illegal_o  (illegal)
    );

    assign accept      = (state_q == IDLE) && req_valid_i;
    assign enter_resp  = (accept && (WAIT_STATES == 0)) ||
                         ((state_q == WAIT) && (cnt_q == 4'd0));
    assign mem_we      = enter_resp && cur_we && !acc_err && !rst;
    assign rsp_rdata_d = (cur_we || acc_err) ? 32'd0 : ld_rdata;
    assign rsp_err_d   = acc_err;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            fun3_q      <= 3'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q        <= req_we_i;
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        fun3_q      <= req_fun3_i;
                        req_ready_q <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rsp_rdata_d;
                            rsp_err_q   <= rsp_err_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WS_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= rsp_err_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: storage has no reset; its contents survive reset and a reset
    // term here would also stop it mapping onto a RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_al[8*b +: 8];
                end
            end
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 uses one wait state,
// instance 1 uses three wait states for the mid-operation reset case.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst         [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic        req_we      [2];
    logic [31:0] req_addr    [2];
    logic [31:0] req_wdata   [2];
    logic [2:0]  req_fun3    [2];
    logic        rsp_valid   [2];
    logic        rsp_ready   [2];
    logic [31:0] rsp_rdata   [2];
    logic        rsp_err     [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_STATES(1)) u_dut1 (
        .clk         (clk),
        .rst         (rst[0]),
        .req_valid_i (req_valid[0]),
        .req_ready_o (req_ready[0]),
        .req_we_i    (req_we[0]),
        .req_addr_i  (req_addr[0]),
        .req_wdata_i (req_wdata[0]),
        .req_fun3_i  (req_fun3[0]),
        .rsp_valid_o (rsp_valid[0]),
        .rsp_ready_i (rsp_ready[0]),
        .rsp_rdata_o (rsp_rdata[0]),
        .rsp_err_o   (rsp_err[0])
    );

    dmem_responder #(.WAIT_STATES(3)) u_dut3 (
        .clk         (clk),
        .rst         (rst[1]),
        .req_valid_i (req_valid[1]),
        .req_ready_o (req_ready[1]),
        .req_we_i    (req_we[1]),
        .req_addr_i  (req_addr[1]),
        .req_wdata_i (req_wdata[1]),
        .req_fun3_i  (req_fun3[1]),
        .rsp_valid_o (rsp_valid[1]),
        .rsp_ready_i (rsp_ready[1]),
        .rsp_rdata_o (rsp_rdata[1]),
        .rsp_err_o   (rsp_err[1])
    );

    // Full transaction; lat counts edges from the start of the accept cycle
    // until rsp_valid is seen.
    task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] fun3,
                          output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_fun3[d]  = fun3;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            req_valid[d] = 1'b0;
        end while (!rsp_valid[d] && lat < 32);
        checks++;
        if (lat >= 32) begin
            errors++;
            $display("FAIL rsp_timeout dut%0d addr=%h: no response within 32 cycles", d, addr);
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(negedge clk);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) rst[d] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) rst[d] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 ||
                rsp_rdata[d] !== 32'd0 || rsp_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
            end
        end
    endtask

    task automatic test_word_latency();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, rd, er, lat);
        checks++;
        if (lat !== 2 || rd !== 32'd0 || er !== 1'b0) begin
            errors++;
            $display("FAIL sw_latency: lat=%0d rdata=%h err=%b, want 2 0 0", lat, rd, er);
        end
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL rsp_release: valid=%b ready=%b, want 0 1", rsp_valid[0], req_ready[0]);
        end
        do_req(0, 1'b0, 32'h10, 32'h0, 3'd2, rd, er, lat);
        checks++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL lw_latency: lat=%0d rdata=%h err=%b, want 2 deadbeef 0", lat, rd, er);
        end
    endtask

    task automatic test_subword_load();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] addrs [4] = '{32'h23, 32'h23, 32'h22, 32'h20};
        logic [2:0]  f3s   [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        do_req(0, 1'b1, 32'h20, 32'h80FF7F01, 3'd2, rd, er, lat);
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1'b0, addrs[i], 32'h0, f3s[i], rd, er, lat);
            checks++;
            if (rd !== exps[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL subload%0d f3=%0d addr=%h: rdata=%h err=%b, want %h 0",
                         i, f3s[i], addrs[i], rd, er, exps[i]);
            end
        end
    endtask

    task automatic test_subword_store();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(0, 1'b1, 32'h21, 32'h000000AA, 3'd0, rd, er, lat);
        do_req(0, 1'b0, 32'h20, 32'h0, 3'd2, rd, er, lat);
        checks++;
        if (rd !== 32'h80FFAA01 || er !== 1'b0) begin
            errors++;
            $display("FAIL sb_merge: rdata=%h err=%b, want 80ffaa01 0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(0, 1'b0, 32'h22, 32'h0, 3'd2, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            errors++;
            $display("FAIL lw_misalign: rdata=%h err=%b, want 0 1", rd, er);
        end
        do_req(0, 1'b1, 32'h21, 32'h1234, 3'd1, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1 || lat !== 2) begin
            errors++;
            $display("FAIL sh_misalign: rdata=%h err=%b lat=%0d, want 0 1 2", rd, er, lat);
        end
        do_req(0, 1'b0, 32'h20, 32'h0, 3'd2, rd, er, lat);
        checks++;
        if (rd !== 32'h80FFAA01 || er !== 1'b0) begin
            errors++;
            $display("FAIL sh_nowrite: rdata=%h err=%b, want 80ffaa01 0", rd, er);
        end
        do_req(0, 1'b0, 32'h00100000, 32'h0, 3'd2, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            errors++;
            $display("FAIL out_of_range: rdata=%h err=%b, want 0 1", rd, er);
        end
        do_req(0, 1'b0, 32'h20, 32'h0, 3'd3, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            errors++;
            $display("FAIL bad_fun3: rdata=%h err=%b, want 0 1", rd, er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h10;
        req_fun3[0]  = 3'd2;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid[0] && n < 32) begin
            @(posedge clk);
            #1;
            n++;
        end
        // A store offered while the response is held must be ignored.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_wdata[0] = 32'h55555555;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEADBEEF ||
                rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: valid=%b rdata=%h err=%b ready=%b, want 1 deadbeef 0 0",
                         i, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]);
            end
        end
        req_valid[0] = 1'b0;
        req_we[0]    = 1'b0;
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 ||
            rsp_rdata[0] !== 32'd0 || rsp_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL release: valid=%b ready=%b rdata=%h err=%b, want 0 1 0 0",
                     rsp_valid[0], req_ready[0], rsp_rdata[0], rsp_err[0]);
        end
        do_req(0, 1'b0, 32'h10, 32'h0, 3'd2, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL ignored_req: rdata=%h err=%b, want deadbeef 0", rd, er);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1, 1'b1, 32'h30, 32'h22222222, 3'd2, rd, er, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL ws3_latency: lat=%0d, want 4", lat);
        end
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h30;
        req_wdata[1] = 32'h11111111;
        req_fun3[1]  = 3'd2;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        checks++;
        if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL midop_reset: valid=%b ready=%b, want 0 1", rsp_valid[1], req_ready[1]);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL midop_stale_rsp: valid=%b, want 0", rsp_valid[1]);
        end
        do_req(1, 1'b0, 32'h30, 32'h0, 3'd2, rd, er, lat);
        checks++;
        if (rd !== 32'h22222222 || er !== 1'b0) begin
            errors++;
            $display("FAIL midop_nowrite: rdata=%h err=%b, want 22222222 0", rd, er);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            req_fun3[d]  = 3'd0;
            rsp_ready[d] = 1'b0;
        end
        test_reset();
        test_word_latency();
        test_subword_load();
        test_subword_store();
        test_errors();
        test_backpressure();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
